// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction words over an
// Avalon-style bus and hands them to decode with a valid/ready handshake.
// Taken branches/jumps redirect the PC after their delay-slot instruction.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        pending_q, pending_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        fault_q, fault_d;

    logic        handshake;
    logic        fetch_done;
    logic        use_redirect;
    logic        misaligned;
    logic [31:0] next_pc;

    // Handshake/completion strobes and next-PC selection (live redirect beats stored one)
    always_comb begin
        handshake    = (state_q == S_HOLD) && instr_ready;
        fetch_done   = (state_q == S_FETCH) && !imem_waitrequest;
        use_redirect = redirect_valid || pending_q;
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (pending_q) begin
            next_pc = target_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end
        misaligned = use_redirect && (next_pc[1:0] != 2'b00);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (fetch_done) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    if (misaligned || (next_pc == HALT_ADDR)) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        imem_read    = (state_q == S_FETCH);
        imem_address = pc_q;
        instr_valid  = (state_q == S_HOLD);
        active       = (state_q != S_HALTED);
        instr        = instr_q;
        instr_pc     = instr_pc_q;
        fault        = fault_q;
    end

    // Datapath next values: capture on fetch, advance PC on handshake, latch redirects
    always_comb begin
        pc_d       = pc_q;
        target_d   = target_q;
        pending_d  = pending_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;

        if (fetch_done) begin
            instr_d    = imem_readdata;
            instr_pc_d = pc_q;
        end

        if (handshake) begin
            pending_d = 1'b0;
            if (misaligned) begin
                fault_d = 1'b1;
            end else begin
                pc_d = next_pc;
            end
        end else if (redirect_valid &&
                     ((state_q == S_FETCH) || (state_q == S_HOLD))) begin
            // Redirect arrives while the delay slot is in flight: apply after it is accepted
            pending_d = 1'b1;
            target_d  = redirect_target;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            target_q   <= '0;
            pending_q  <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            target_q   <= target_d;
            pending_q  <= pending_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
        end
    end

endmodule
